// File: rtl/tb_cfg_sweeper.sv
// rtl/tb_cfg_sweeper.sv - runs a DUT under one or all configuration indices and records pass/fail per index.
// Optional run watchdog enabled by defining SWEEP_TIMEOUT_EN.
module tb_cfg_sweeper #(
  parameter int NumCfgs       = 3,
  parameter int ResetCycles   = 16,
  parameter int TimeoutCycles = 1000000
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             sweep_i,
  input  logic [((NumCfgs > 1) ? $clog2(NumCfgs) : 1)-1:0] cfg_sel_i,
  input  logic                             dut_done_i,
  input  logic [31:0]                      dut_exit_i,
  output logic                             dut_rst_o,
  output logic [((NumCfgs > 1) ? $clog2(NumCfgs) : 1)-1:0] cfg_idx_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [NumCfgs-1:0]               pass_o,
  output logic [NumCfgs-1:0]               fail_o,
  output logic [NumCfgs-1:0]               tmo_o
);

  localparam int IdxW    = (NumCfgs > 1) ? $clog2(NumCfgs) : 1;
  localparam int RstCntW = $clog2(ResetCycles + 1);
  localparam logic [RstCntW-1:0] RstLast  = RstCntW'(ResetCycles - 1);
  localparam logic [IdxW-1:0]    LastIdx  = IdxW'(NumCfgs - 1);
  localparam logic [IdxW:0]      NumCfgsW = (IdxW + 1)'(NumCfgs);

  // Parameter legality guard; the block is intentionally empty.
  if (NumCfgs < 1 || ResetCycles < 1 || TimeoutCycles < 1) begin : g_illegal_params
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_RECORD,
    S_FIN
  } state_t;

  state_t               r_state;
  logic [IdxW-1:0]      r_cfg_idx;
  logic                 r_sweep;
  logic [RstCntW-1:0]   r_rst_cnt;
  logic [31:0]          r_exit;
  logic [NumCfgs-1:0]   r_pass;
  logic [NumCfgs-1:0]   r_fail;
  logic                 r_done;
  logic                 r_dut_rst;
  logic                 w_sel_bad;

`ifdef SWEEP_TIMEOUT_EN
  localparam int TmoCntW = $clog2(TimeoutCycles + 1);
  localparam logic [TmoCntW-1:0] TmoLast = TmoCntW'(TimeoutCycles - 1);
  logic [TmoCntW-1:0]   r_tmo_cnt;
  logic                 r_tmo_hit;
  logic [NumCfgs-1:0]   r_tmo;
`endif

  assign w_sel_bad = ({1'b0, cfg_sel_i} >= NumCfgsW);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cfg_idx <= '0;
      r_sweep   <= 1'b0;
      r_rst_cnt <= '0;
      r_exit    <= '0;
      r_pass    <= '0;
      r_fail    <= '0;
      r_done    <= 1'b0;
      r_dut_rst <= 1'b1;
`ifdef SWEEP_TIMEOUT_EN
      r_tmo_cnt <= '0;
      r_tmo_hit <= 1'b0;
      r_tmo     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dut_rst <= 1'b0;
          if (start_i) begin
            r_pass <= '0;
            r_fail <= '0;
`ifdef SWEEP_TIMEOUT_EN
            r_tmo  <= '0;
`endif
            // An out-of-range single index completes immediately with empty masks.
            if (!sweep_i && w_sel_bad) begin
              r_done <= 1'b1;
            end else begin
              r_sweep   <= sweep_i;
              r_cfg_idx <= sweep_i ? '0 : cfg_sel_i;
              r_rst_cnt <= '0;
              r_dut_rst <= 1'b1;
              r_state   <= S_RESET;
            end
          end
        end
        S_RESET: begin
          if (r_rst_cnt == RstLast) begin
            r_dut_rst <= 1'b0;
            r_state   <= S_RUN;
`ifdef SWEEP_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_tmo_hit <= 1'b0;
`endif
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // A done strobe takes priority over a timeout in the same cycle.
          if (dut_done_i) begin
            r_exit  <= dut_exit_i;
            r_state <= S_RECORD;
          end
`ifdef SWEEP_TIMEOUT_EN
          else if (r_tmo_cnt == TmoLast) begin
            r_tmo_hit <= 1'b1;
            r_state   <= S_RECORD;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        S_RECORD: begin
`ifdef SWEEP_TIMEOUT_EN
          if (r_tmo_hit) r_tmo[r_cfg_idx] <= 1'b1;
          else
`endif
          if (r_exit == '0) r_pass[r_cfg_idx] <= 1'b1;
          else              r_fail[r_cfg_idx] <= 1'b1;
          if (r_sweep && (r_cfg_idx < LastIdx)) begin
            r_cfg_idx <= r_cfg_idx + 1'b1;
            r_rst_cnt <= '0;
            r_dut_rst <= 1'b1;
            r_state   <= S_RESET;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dut_rst_o = r_dut_rst;
  assign cfg_idx_o = r_cfg_idx;
  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = r_done;
  assign pass_o    = r_pass;
  assign fail_o    = r_fail;
`ifdef SWEEP_TIMEOUT_EN
  assign tmo_o     = r_tmo;
`else
  assign tmo_o     = '0;
`endif

endmodule

// File: tb/tb_tb_cfg_sweeper.sv
// tb/tb_tb_cfg_sweeper.sv - scoreboard bench for tb_cfg_sweeper: reset pulses and campaign results.
module tb_tb_cfg_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sweep = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic        dut_done = 1'b0;
  logic [31:0] dut_exit = 32'hdead_beef;
  logic        dut_rst;
  logic [1:0]  cfg_idx;
  logic        busy;
  logic        done;
  logic [2:0]  pass_m;
  logic [2:0]  fail_m;
  logic [2:0]  tmo_m;

  tb_cfg_sweeper #(
    .NumCfgs      (3),
    .ResetCycles  (16),
    .TimeoutCycles(100)
  ) u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .sweep_i   (sweep),
    .cfg_sel_i (cfg_sel),
    .dut_done_i(dut_done),
    .dut_exit_i(dut_exit),
    .dut_rst_o (dut_rst),
    .cfg_idx_o (cfg_idx),
    .busy_o    (busy),
    .done_o    (done),
    .pass_o    (pass_m),
    .fail_o    (fail_m),
    .tmo_o     (tmo_m)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         exp_runs[$];
  logic [8:0] exp_res[$];
  int         rst_w = 0;
  logic       prev_done = 1'b0;
  int         e_idx;
  logic [8:0] e_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each DUT reset pulse pops an expected index, each done pulse pops expected masks.
  always @(negedge clk) begin
    if (rst) begin
      rst_w = 0;
    end else if (busy && dut_rst) begin
      rst_w++;
    end else if (rst_w != 0) begin
      if (exp_runs.size() == 0) begin
        check("unexpected_reset_pulse", 32'd1, 32'd0);
      end else begin
        e_idx = exp_runs.pop_front();
        check("rst_width", rst_w, 32'd16);
        check("run_idx", {30'd0, cfg_idx}, e_idx);
      end
      rst_w = 0;
    end
    if (done) begin
      if (prev_done) check("done_one_cycle", 32'd1, 32'd0);
      if (exp_res.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e_res = exp_res.pop_front();
        check("res_pass", {29'd0, pass_m}, {29'd0, e_res[8:6]});
        check("res_fail", {29'd0, fail_m}, {29'd0, e_res[5:3]});
        check("res_tmo",  {29'd0, tmo_m},  {29'd0, e_res[2:0]});
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_campaign(input logic sw, input logic [1:0] sel);
    sweep = sw;
    cfg_sel = sel;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy && dut_rst) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (!dut_rst) begin
          ok = 1'b1;
          break;
        end
      end
    end
    if (!ok) check("wait_run_timeout", 32'd1, 32'd0);
  endtask

  task automatic finish_run(input logic [31:0] code, input int delay);
    bit ok;
    wait_run(ok);
    if (!ok) return;
    repeat (delay) tick();
    dut_exit = code;
    dut_done = 1'b1;
    tick();
    dut_done = 1'b0;
    dut_exit = 32'hdead_beef;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bit ok;
    int run_len;
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int run_len;
    repeat (3) @(negedge clk);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_dut_rst", {31'd0, dut_rst}, 32'd1);
    check("rst_cfg_idx", {30'd0, cfg_idx}, 32'd0);
    check("rst_masks",   {23'd0, pass_m, fail_m, tmo_m}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("dut_rst_before_edge", {31'd0, dut_rst}, 32'd1);
    @(negedge clk);
    check("dut_rst_after_edge",  {31'd0, dut_rst}, 32'd0);
    tick();

    // Sweep, all pass; a busy start and an out-of-RUN done are both ignored.
    exp_runs.push_back(0); exp_runs.push_back(1); exp_runs.push_back(2);
    exp_res.push_back({3'b111, 3'b000, 3'b000});
    start_campaign(1'b1, 2'd0);
    start = 1'b1; sweep = 1'b0; cfg_sel = 2'd2;
    dut_done = 1'b1; dut_exit = 32'h5;
    tick();
    start = 1'b0; dut_done = 1'b0; dut_exit = 32'hdead_beef;
    finish_run(32'h0, 3);
    finish_run(32'h0, 1);
    finish_run(32'h0, 5);
    wait_idle();
    repeat (4) tick();
    check("hold_cfg_idx", {30'd0, cfg_idx}, 32'd2);
    check("hold_pass",    {29'd0, pass_m},  32'd7);

    // Single mode index 1 with a nonzero exit code.
    exp_runs.push_back(1);
    exp_res.push_back({3'b000, 3'b010, 3'b000});
    start_campaign(1'b0, 2'd1);
    finish_run(32'h5, 2);
    wait_idle();
    tick();

    // Out-of-range single index: no DUT reset, immediate done with cleared masks.
    exp_res.push_back({3'b000, 3'b000, 3'b000});
    start_campaign(1'b0, 2'd3);
    @(negedge clk);
    check("bad_sel_busy",    {31'd0, busy},    32'd0);
    check("bad_sel_dut_rst", {31'd0, dut_rst}, 32'd0);
    repeat (3) tick();

    // Mixed sweep: last index fails.
    exp_runs.push_back(0); exp_runs.push_back(1); exp_runs.push_back(2);
    exp_res.push_back({3'b011, 3'b100, 3'b000});
    start_campaign(1'b1, 2'd3);
    finish_run(32'h0, 0);
    finish_run(32'h0, 2);
    finish_run(32'h8000_0000, 4);
    wait_idle();
    tick();

`ifdef SWEEP_TIMEOUT_EN
    // Index 0 never finishes: 100 RUN cycles plus one RECORD cycle before the next reset.
    exp_runs.push_back(0); exp_runs.push_back(1); exp_runs.push_back(2);
    exp_res.push_back({3'b010, 3'b100, 3'b001});
    start_campaign(1'b1, 2'd0);
    wait_run(ok);
    run_len = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dut_rst) break;
      run_len++;
    end
    check("tmo_run_len", run_len, 32'd101);
    finish_run(32'h0, 2);
    finish_run(32'h7, 2);
    wait_idle();
    tick();
`endif

    // Reset in the middle of index 1's RUN aborts without a done pulse.
    exp_runs.push_back(0); exp_runs.push_back(1);
    start_campaign(1'b1, 2'd0);
    finish_run(32'h0, 1);
    wait_run(ok);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort_busy",    {31'd0, busy},    32'd0);
    check("abort_dut_rst", {31'd0, dut_rst}, 32'd1);
    check("abort_cfg_idx", {30'd0, cfg_idx}, 32'd0);
    check("abort_masks",   {23'd0, pass_m, fail_m, tmo_m}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();

    check("runs_left",    exp_runs.size(), 32'd0);
    check("results_left", exp_res.size(),  32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tb_cfg_sweeper.md
TB_CFG_SWEEPER -- requirements
Module: tb_cfg_sweeper

Interface
REQ-001 The module SHALL have parameter NumCfgs, default 3, number of selectable Cheshire configuration indices (>=1).
REQ-002 The module SHALL have parameter ResetCycles, default 16, cycles the DUT reset is held per run (>=1).
REQ-003 The module SHALL have parameter TimeoutCycles, default 1000000, maximum RUN cycles before a run is declared timed out (>=1).
REQ-004 The module SHALL derive localparam IdxW = max(1, clog2(NumCfgs)) for all index ports.
REQ-005 The module SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-007 The module SHALL have port start_i, input, 1, one-cycle request that starts a campaign and is sampled only in IDLE.
REQ-008 The module SHALL have port sweep_i, input, 1, campaign mode sampled with start_i: 0 = single config, 1 = sweep all configs.
REQ-009 The module SHALL have port cfg_sel_i, input, IdxW, config index for single mode.
REQ-010 The module SHALL have port dut_done_i, input, 1, DUT end-of-test strobe.
REQ-011 The module SHALL have port dut_exit_i, input, 32, DUT exit code, valid with dut_done_i; 0 = pass.
REQ-012 The module SHALL have port dut_rst_o, output, 1, active-high reset to the DUT instance.
REQ-013 The module SHALL have port cfg_idx_o, output, IdxW, index of the config currently under test.
REQ-014 The module SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-015 The module SHALL have port done_o, output, 1, one-cycle pulse when a campaign completes.
REQ-016 The module SHALL have ports pass_o, fail_o and tmo_o, output, NumCfgs each, per-config result bits.

Function
REQ-017 The FSM SHALL have states IDLE, RESET, RUN, RECORD and FIN.
REQ-018 In IDLE, start_i=1 SHALL clear pass_o, fail_o and tmo_o, load cfg_idx_o (cfg_sel_i in single mode, 0 in sweep mode), latch the mode and go to RESET.
REQ-019 In single mode, a cfg_sel_i >= NumCfgs SHALL be ignored: the FSM stays in IDLE and pulses done_o with all masks 0.
REQ-020 In RESET, dut_rst_o SHALL be 1 for exactly ResetCycles cycles, then the FSM SHALL enter RUN with dut_rst_o=0.
REQ-021 dut_rst_o SHALL be 0 in IDLE, RUN, RECORD and FIN.
REQ-022 In RUN, dut_done_i=1 SHALL capture dut_exit_i and move to RECORD on the next cycle.
REQ-023 dut_done_i SHALL be ignored outside RUN.
REQ-024 In RECORD, exit 0 SHALL set pass_o[cfg_idx_o] and nonzero SHALL set fail_o[cfg_idx_o]; exactly one of pass, fail or tmo SHALL be set per run.
REQ-025 After RECORD in sweep mode with cfg_idx_o < NumCfgs-1, the FSM SHALL increment cfg_idx_o and go to RESET; otherwise it SHALL go to FIN.
REQ-026 cfg_idx_o SHALL never exceed NumCfgs-1 and SHALL NOT wrap.
REQ-027 FIN SHALL assert done_o for one cycle and return to IDLE; masks and cfg_idx_o SHALL hold until the next start.
REQ-028 start_i SHALL be ignored while busy_o=1.

Reset
REQ-029 While rst_i=1, the block SHALL go to IDLE, set cfg_idx_o=0, all masks=0, busy_o=0, done_o=0 and dut_rst_o=1.
REQ-030 After release, dut_rst_o SHALL drop on the first clock edge.
REQ-031 Reset asserted mid-campaign SHALL abort it with no done_o pulse.

Configuration
REQ-032 With SWEEP_TIMEOUT_EN defined, a counter SHALL clear on RUN entry and count RUN cycles.
REQ-033 With SWEEP_TIMEOUT_EN defined, reaching TimeoutCycles without dut_done_i SHALL set tmo_o[cfg_idx_o] and go to RECORD without setting pass or fail; when done and timeout fall in the same cycle, done SHALL win.
REQ-034 Without SWEEP_TIMEOUT_EN, no counter SHALL exist, RUN SHALL wait indefinitely and tmo_o SHALL be constant 0.

Verification
REQ-035 NumCfgs=3, sweep, exits 0,0,0 -> cfg_idx_o steps 0,1,2; pass_o=3'b111; fail_o=0; one done_o pulse.
REQ-036 Single mode, cfg_sel_i=1, exit 0x5 -> only index 1 runs; fail_o=3'b010; pass_o=0.
REQ-037 Single mode, cfg_sel_i=3 with NumCfgs=3 -> no reset pulse; done_o pulses; all masks 0.
REQ-038 SWEEP_TIMEOUT_EN, TimeoutCycles=100, no dut_done_i at index 0 -> tmo_o[0]=1 after 100 RUN cycles; sweep continues.
REQ-039 rst_i asserted during RUN of index 1 -> immediate IDLE, masks 0, dut_rst_o=1, no done_o.
REQ-040 dut_rst_o high width -> exactly ResetCycles=16 cycles per config; start_i while busy -> no effect.
